// File: rtl/uart_rx_to_ram.sv
// 8N1 UART receiver that packs byte pairs big-endian into 16-bit words for a 64-entry RAM.
// Optional pending-byte timeout is enabled by defining UART_RX_TO_RAM_TIMEOUT_EN.
module uart_rx_to_ram #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_RX,
    output logic        write_enable_to_ram,
    output logic [5:0]  address_to_ram,
    output logic [15:0] data_to_ram,
    output logic        frame_done,
    output logic        frame_error
);

    localparam int unsigned HalfBit  = CLKS_PER_BIT / 2;
    localparam logic [11:0] BitLast  = 12'(CLKS_PER_BIT - 1);
    localparam logic [11:0] HalfLast = 12'(HalfBit - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic [1:0]  sync_q;
    logic        rx;
    logic        rx_prev_q;

    logic [1:0]  state_q, state_d;
    logic [11:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_valid;
    logic        byte_error;

    logic        pending_q, pending_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic        we_q, we_d;
    logic [5:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

`ifdef UART_RX_TO_RAM_TIMEOUT_EN
    localparam logic [16:0] IdleLast = 17'(16 * CLKS_PER_BIT - 1);
    logic [16:0] idle_cnt_q, idle_cnt_d;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], uart_RX};
            rx_prev_q <= sync_q[1];
        end
    end

    assign rx = sync_q[1];

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        byte_error = 1'b0;
        case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (rx_prev_q && !rx) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (clk_cnt_q == HalfLast) begin
                    clk_cnt_d = '0;
                    state_d   = rx ? StIdle : StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + 12'd1;
                end
            end
            StData: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 12'd1;
                end
            end
            StStop: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d  = '0;
                    state_d    = StIdle;
                    byte_valid = rx;
                    byte_error = !rx;
                end else begin
                    clk_cnt_d = clk_cnt_q + 12'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        pending_d = pending_q;
        hi_byte_d = hi_byte_q;
        we_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = byte_error;
        data_d    = data_q;
        addr_d    = we_q ? addr_q + 6'd1 : addr_q;
`ifdef UART_RX_TO_RAM_TIMEOUT_EN
        idle_cnt_d = '0;
        if (pending_q && (state_q == StIdle) && rx) begin
            if (idle_cnt_q == IdleLast) begin
                pending_d = 1'b0;
            end else begin
                idle_cnt_d = idle_cnt_q + 17'd1;
            end
        end
`else
        // A pending high byte waits indefinitely for its partner.
`endif
        // A completed byte never coincides with a strobe, so addr_q is the write address here.
        if (byte_valid) begin
            if (!pending_q) begin
                hi_byte_d = shift_q;
                pending_d = 1'b1;
            end else begin
                data_d    = {hi_byte_q, shift_q};
                we_d      = 1'b1;
                done_d    = (addr_q == 6'd63);
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
            hi_byte_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            hi_byte_q <= hi_byte_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef UART_RX_TO_RAM_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    assign write_enable_to_ram = we_q;
    assign address_to_ram      = addr_q;
    assign data_to_ram         = data_q;
    assign frame_done          = done_q;
    assign frame_error         = err_q;

endmodule

// File: tb/tb_uart_rx_to_ram.sv
// Directed bench for uart_rx_to_ram at 16 clocks per bit; expected words are hand-derived.
module tb_uart_rx_to_ram;

    localparam int unsigned Cpb = 16;

    logic        clk;
    logic        reset;
    logic        uart_RX;
    logic        write_enable_to_ram;
    logic [5:0]  address_to_ram;
    logic [15:0] data_to_ram;
    logic        frame_done;
    logic        frame_error;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [5:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    logic        wr_done[$];

    uart_rx_to_ram #(
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .uart_RX            (uart_RX),
        .write_enable_to_ram(write_enable_to_ram),
        .address_to_ram     (address_to_ram),
        .data_to_ram        (data_to_ram),
        .frame_done         (frame_done),
        .frame_error        (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every strobe cycle and pulse; sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (write_enable_to_ram) begin
            wr_addr.push_back(address_to_ram);
            wr_data.push_back(data_to_ram);
            wr_done.push_back(frame_done);
        end
        if (frame_done) done_cnt++;
        if (frame_error) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_done.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic idle(input int n);
        uart_RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        uart_RX = v;
        repeat (Cpb) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        uart_RX = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        clear_log();
    endtask

    initial begin
        logic [15:0] word;
        reset   = 1'b0;
        uart_RX = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_we", write_enable_to_ram, 0);
        check("rst_addr", address_to_ram, 0);
        check("rst_data", data_to_ram, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", frame_error, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        clear_log();

        // Single pair
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        idle(8);
        check("pair_nwr", wr_data.size(), 1);
        check("pair_addr", wr_addr[0], 0);
        check("pair_data", wr_data[0], 16'hA53C);
        check("pair_next_addr", address_to_ram, 1);
        check("pair_err", err_cnt, 0);

        // 128 back-to-back bytes fill all 64 words and wrap
        do_reset();
        for (int i = 0; i < 128; i++) send_byte(8'(i), 1'b1);
        idle(8);
        check("burst_nwr", wr_data.size(), 64);
        for (int n = 0; n < 64; n++) begin
            word = {8'(2 * n), 8'(2 * n + 1)};
            check($sformatf("burst_addr%0d", n), wr_addr[n], 32'(n));
            check($sformatf("burst_data%0d", n), wr_data[n], word);
        end
        check("burst_done_cnt", done_cnt, 1);
        check("burst_done_at63", wr_done[63], 1);
        check("burst_last_data", wr_data[63], 16'h7E7F);
        check("burst_wrap_addr", address_to_ram, 0);

        // Bad stop bit discards the byte; line must go high again before the next start
        do_reset();
        send_byte(8'h11, 1'b0);
        idle(2 * Cpb);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        idle(8);
        check("ferr_cnt", err_cnt, 1);
        check("ferr_nwr", wr_data.size(), 1);
        check("ferr_addr", wr_addr[0], 0);
        check("ferr_data", wr_data[0], 16'h2233);

        // Short low glitch is rejected; a following pair is received from a clean IDLE
        do_reset();
        uart_RX = 1'b0;
        repeat (4) @(negedge clk);
        idle(4 * Cpb);
        check("glitch_nwr", wr_data.size(), 0);
        check("glitch_err", err_cnt, 0);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b1);
        idle(8);
        check("glitch_after_nwr", wr_data.size(), 1);
        check("glitch_after_data", wr_data[0], 16'h5AC3);
        check("glitch_after_addr", address_to_ram, 1);

        // Reset during bit 4 of the second byte of a pair
        clear_log();
        send_byte(8'hAB, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        uart_RX = 1'b0;
        repeat (Cpb / 2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_we", write_enable_to_ram, 0);
        check("midrst_addr", address_to_ram, 0);
        check("midrst_data", data_to_ram, 0);
        check("midrst_done", frame_done, 0);
        check("midrst_err", frame_error, 0);
        uart_RX = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(2 * Cpb);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle(8);
        check("midrst_nwr", wr_data.size(), 1);
        check("midrst_wr_addr", wr_addr[0], 0);
        check("midrst_wr_data", wr_data[0], 16'h1234);

        // Long idle between bytes of a pair
        do_reset();
        send_byte(8'h55, 1'b1);
        idle(20 * Cpb);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        idle(8);
        check("timeout_nwr", wr_data.size(), 1);
        check("timeout_addr", wr_addr[0], 0);
`ifdef UART_RX_TO_RAM_TIMEOUT_EN
        check("timeout_data", wr_data[0], 16'h6677);
`else
        check("timeout_data", wr_data[0], 16'h5566);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
